// File: rtl/loadenc_seq.sv
// loadenc_seq: multi-register load sequencer.
// Takes a request mask and issues one register index per accepted cycle on
// loadsel_o, driving the IDLESEL sentinel whenever no load is being issued.
// Build option: define LOADENC_DESC_EN to issue the highest pending index
// first (descending, POP-style); left undefined, the lowest index goes first.
module loadenc_seq #(
  parameter int NREGS   = 32,
  parameter int SELW    = 6,
  parameter int IDLESEL = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NREGS-1:0] reqmask_i,
  input  logic             ready_i,
  output logic [SELW-1:0]  loadsel_o,
  output logic             loadvalid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SELW-1:0]  count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NREGS-1:0]   pending_q, pending_d;
  logic [SELW-1:0]    count_q, count_d;

  logic [SELW-1:0]    selIdx;
  logic [NREGS-1:0]   selOneHot;
  logic [NREGS-1:0]   pendingCleared;

  // Pick the next register to load from the pending set, plus its one-hot mask.
  always_comb begin
    selIdx    = '0;
    selOneHot = '0;
`ifdef LOADENC_DESC_EN
    for (int i = 0; i < NREGS; i++) begin
      if (pending_q[i]) begin
        selIdx    = SELW'(i);
        selOneHot = '0;
        selOneHot[i] = 1'b1;
      end
    end
`else
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        selIdx    = SELW'(i);
        selOneHot = '0;
        selOneHot[i] = 1'b1;
      end
    end
`endif
  end

  assign pendingCleared = pending_q & ~selOneHot;

  // Next-state logic: accept a start in IDLE, retire one index per ready in BUSY.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          count_d = '0;
          if (reqmask_i != '0) begin
            pending_d = reqmask_i;
            state_d   = BUSY;
          end else begin
            state_d   = DONE;
          end
        end
      end
      BUSY: begin
        if (ready_i) begin
          pending_d = pendingCleared;
          count_d   = count_q + SELW'(1);
          if (pendingCleared == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State register; reset discards any sequence in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    loadsel_o   = SELW'(IDLESEL);
    loadvalid_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      BUSY: begin
        loadsel_o   = selIdx;
        loadvalid_o = 1'b1;
        busy_o      = 1'b1;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        loadsel_o   = SELW'(IDLESEL);
      end
    endcase
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_loadenc_seq.sv
// tb_loadenc_seq: directed bench for loadenc_seq with hand-computed expectations.
// Expected issue order follows LOADENC_DESC_EN when the bench is built with it.
module tb_loadenc_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] reqmask;
  logic        ready;
  logic [5:0]  loadsel;
  logic        loadvalid;
  logic        busy;
  logic        done;
  logic [5:0]  count;

  int errCount   = 0;
  int checkCount = 0;

`ifdef LOADENC_DESC_EN
  localparam int S0 = 5, S1 = 2, S2 = 0;
  localparam int T0 = 31, T1 = 0;
  localparam bit DESC = 1'b1;
`else
  localparam int S0 = 0, S1 = 2, S2 = 5;
  localparam int T0 = 0, T1 = 31;
  localparam bit DESC = 1'b0;
`endif

  loadenc_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .reqmask_i   (reqmask),
    .ready_i     (ready),
    .loadsel_o   (loadsel),
    .loadvalid_o (loadvalid),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive the request inputs for the next clock edge.
  task automatic applyStimulus(input logic s, input logic [31:0] m, input logic r);
    start   = s;
    reqmask = m;
    ready   = r;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot check.
  task automatic checkAll(input string tag, input int sel, input bit v, input bit b,
                          input bit d, input int cnt);
    checkOutput({tag, ".loadsel"},   32'(loadsel),   32'(sel));
    checkOutput({tag, ".loadvalid"}, 32'(loadvalid), 32'(v));
    checkOutput({tag, ".busy"},      32'(busy),      32'(b));
    checkOutput({tag, ".done"},      32'(done),      32'(d));
    checkOutput({tag, ".count"},     32'(count),     32'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset held two cycles, then idle.
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkAll("reset", 32, 0, 0, 0, 0);

    // Basic three-register sequence with ready held high.
    applyStimulus(1'b1, 32'h0000_0025, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkAll("seqA0", S0, 1, 1, 0, 0);
    tick();
    checkAll("seqA1", S1, 1, 1, 0, 1);
    tick();
    checkAll("seqA2", S2, 1, 1, 0, 2);
    tick();
    checkAll("seqAdone", 32, 0, 1, 1, 3);
    tick();
    checkAll("seqAidle", 32, 0, 0, 0, 3);

    // Backpressure: ready low for three cycles on the middle index.
    applyStimulus(1'b1, 32'h0000_0025, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkAll("holdB0", S0, 1, 1, 0, 0);
    tick();
    checkAll("holdB1", S1, 1, 1, 0, 1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("holdB.loadsel", 32'(loadsel), 32'(S1));
      checkOutput("holdB.count",   32'(count),   32'd1);
      checkOutput("holdB.valid",   32'(loadvalid), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkAll("holdB2", S2, 1, 1, 0, 2);
    tick();
    checkAll("holdBdone", 32, 0, 1, 1, 3);
    tick();
    checkAll("holdBidle", 32, 0, 0, 0, 3);

    // Empty mask still produces a single done pulse.
    applyStimulus(1'b1, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkAll("emptyDone", 32, 0, 1, 1, 0);
    tick();
    checkAll("emptyIdle", 32, 0, 0, 0, 0);

    // Start during BUSY is ignored; reset mid-sequence discards pending bits.
    applyStimulus(1'b1, 32'h8000_0001, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0000_00F0, 1'b0);
    checkAll("ignT0", T0, 1, 1, 0, 0);
    tick();
    checkAll("ignHold", T0, 1, 1, 0, 0);
    applyStimulus(1'b1, 32'h0000_00F0, 1'b1);
    tick();
    checkAll("ignT1", T1, 1, 1, 0, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    rst = 1'b0;
    checkAll("midReset", 32, 0, 0, 0, 0);
    tick();
    checkAll("midResetIdle", 32, 0, 0, 0, 0);

    // Full mask: all 32 indices in order, count reaches 32 without wrap.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      checkOutput("full.loadsel", 32'(loadsel), DESC ? 32'(31 - i) : 32'(i));
      checkOutput("full.count",   32'(count),   32'(i));
      tick();
    end
    checkAll("fullDone", 32, 0, 1, 1, 32);
    tick();
    checkAll("fullIdle", 32, 0, 0, 0, 32);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
